// File: rtl/conv_line_ctrl_if.sv
// rtl/conv_line_ctrl_if.sv - handshake and datapath bundle for the conv line controller
interface conv_line_ctrl_if #(
    parameter int I_X = 8,
    parameter int I_W = 8
);
    logic                  i_start;
    logic                  i_clear;
    logic                  i_w_valid;
    logic signed [I_W-1:0] i_w;
    logic                  o_w_ready;
    logic                  i_x_valid;
    logic signed [I_X-1:0] i_x;
    logic                  o_x_ready;
    logic signed [I_X-1:0] o_pe_x;
    logic signed [I_W-1:0] o_pe_w;
    logic                  o_psum_valid;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_clear, i_w_valid, i_w, i_x_valid, i_x,
        output o_w_ready, o_x_ready, o_pe_x, o_pe_w, o_psum_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_clear, i_w_valid, i_w, i_x_valid, i_x,
        input  o_w_ready, o_x_ready, o_pe_x, o_pe_w, o_psum_valid, o_busy, o_done
    );
endinterface

// File: rtl/conv_line_ctrl.sv
// rtl/conv_line_ctrl.sv - loads K weights, streams one row of pixels into a K-PE line, tracks psum validity
module conv_line_ctrl #(
    parameter int I_X     = 8,
    parameter int I_W     = 8,
    parameter int K       = 5,
    parameter int ROW_LEN = 32,
    parameter int CW      = 6
) (
    input logic              i_clk,
    input logic              i_rst_n,
    conv_line_ctrl_if.slave  bus
);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            r_state;
    logic [KW-1:0]         r_w_cnt;
    logic [KW-1:0]         r_k_idx;
    logic [CW-1:0]         r_x_cnt;
    logic signed [I_W-1:0] r_w_reg [K];
    logic [K:0]            r_vld_sr;
    logic signed [I_X-1:0] r_pe_x;
    logic signed [I_W-1:0] r_pe_w;

    logic w_x_acc;
    logic w_w_acc;

    assign w_x_acc = (r_state == S_STREAM) && bus.i_x_valid;
    assign w_w_acc = (r_state == S_LOAD_W) && bus.i_w_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_w_cnt  <= '0;
            r_k_idx  <= '0;
            r_x_cnt  <= '0;
            r_vld_sr <= '0;
            r_pe_x   <= '0;
            r_pe_w   <= '0;
        end else if (bus.i_clear) begin
            r_state  <= S_IDLE;
            r_w_cnt  <= '0;
            r_k_idx  <= '0;
            r_x_cnt  <= '0;
            r_vld_sr <= '0;
            r_pe_x   <= '0;
            r_pe_w   <= '0;
        end else begin
            // Bubbles feed zeros into the PE line so the array never needs a stall.
            r_pe_x   <= '0;
            r_pe_w   <= '0;
            r_vld_sr <= {r_vld_sr[K-1:0], w_x_acc};
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= S_LOAD_W;
                        r_w_cnt <= '0;
                        r_x_cnt <= '0;
                        r_k_idx <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (bus.i_w_valid) begin
                        r_w_cnt <= r_w_cnt + 1'b1;
                        if (r_w_cnt == KW'(K - 1)) r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_x_acc) begin
                        r_pe_x  <= bus.i_x;
                        r_pe_w  <= r_w_reg[r_k_idx];
                        r_k_idx <= (r_k_idx == KW'(K - 1)) ? '0 : r_k_idx + 1'b1;
                        r_x_cnt <= r_x_cnt + 1'b1;
                        if (r_x_cnt == CW'(ROW_LEN - 1)) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Once the lower bits are empty, the final psum is on the top tap this cycle.
                    if (r_vld_sr[K-1:0] == '0) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < K; i++) r_w_reg[i] <= '0;
        end else if (w_w_acc && !bus.i_clear) begin
            r_w_reg[r_w_cnt] <= bus.i_w;
        end
    end

    assign bus.o_w_ready    = (r_state == S_LOAD_W);
    assign bus.o_x_ready    = (r_state == S_STREAM);
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_done       = (r_state == S_DONE);
    assign bus.o_psum_valid = r_vld_sr[K];
    assign bus.o_pe_x       = r_pe_x;
    assign bus.o_pe_w       = r_pe_w;
endmodule
